// File: rtl/simon_pkg.sv
// Shared types and helpers for the Simon Says sequence engine.
package simon_pkg;

    typedef enum logic [2:0] {
        IDLE,
        EXTEND,
        PLAY_ON,
        PLAY_OFF,
        WAIT_IN,
        WIN,
        LOSE
    } state_e;

    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    // Index width that never collapses to zero bits for degenerate sizes.
    function automatic int unsigned clog2_min1(input int unsigned v);
        return (v <= 1) ? 1 : $clog2(v);
    endfunction

    // 16-bit Galois LFSR, right shift.
    function automatic logic [15:0] lfsr_next(input logic [15:0] l);
        return (l >> 1) ^ (l[0] ? LFSR_TAPS : 16'h0000);
    endfunction

endpackage

// File: rtl/key_decoder.sv
// Index to one-hot decoder with enable; yields zero when disabled or the
// index is beyond the key count.
module key_decoder #(
    parameter int unsigned N_KEYS = 16
) (
    input  logic                      i_en,
    input  logic [$clog2(N_KEYS)-1:0] i_idx,
    output logic [N_KEYS-1:0]         o_onehot
);

    localparam int unsigned IW = $clog2(N_KEYS);

    always_comb begin
        o_onehot = '0;
        for (int unsigned i = 0; i < N_KEYS; i++) begin
            if (i_en && (i_idx == IW'(i))) begin
                o_onehot[i] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/simon_seq_gen.sv
// Simon Says game core: grows a random key sequence each round, plays it back
// as timed one-hot pulses and checks the player's presses against it.
module simon_seq_gen
    import simon_pkg::*;
#(
    parameter int unsigned N_KEYS     = 16,
    parameter int unsigned MAX_LEN    = 32,
    parameter int unsigned ON_CYCLES  = 8,
    parameter int unsigned OFF_CYCLES = 4,
    parameter logic [15:0] SEED       = 16'hACE1
) (
    input  logic                         clk,
    input  logic                         nrst,
    input  logic                         start,
    input  logic                         key_valid,
    input  logic [N_KEYS-1:0]            key_onehot,
    output logic [N_KEYS-1:0]            disp,
    output logic                         busy,
    output logic                         expect_input,
    output logic                         win,
    output logic                         lose,
    output logic [$clog2(MAX_LEN+1)-1:0] level
);

    localparam int unsigned IW = $clog2(N_KEYS);
    localparam int unsigned LW = $clog2(MAX_LEN + 1);
    localparam int unsigned PW = clog2_min1(MAX_LEN);
    localparam int unsigned TW = clog2_min1((ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES);

    localparam logic [TW-1:0] ON_LAST  = TW'(ON_CYCLES - 1);
    localparam logic [TW-1:0] OFF_LAST = TW'(OFF_CYCLES - 1);
    localparam logic [LW-1:0] LEN_MAX  = LW'(MAX_LEN);

    state_e            r_state;
    state_e            w_state_d;
    logic [15:0]       r_lfsr;
    logic [IW-1:0]     r_mem [MAX_LEN];
    logic [LW-1:0]     r_len;
    logic [PW-1:0]     r_ptr;
    logic [TW-1:0]     r_timer;
    logic [N_KEYS-1:0] r_disp;

    logic [N_KEYS-1:0] w_disp_d;
    logic [N_KEYS-1:0] w_play_onehot;
    logic [N_KEYS-1:0] w_exp_onehot;
    logic [IW-1:0]     w_cur_idx;
    logic [IW-1:0]     w_new_idx;
    logic [PW-1:0]     w_wr_ptr;
    logic              w_on_done;
    logic              w_off_done;
    logic              w_last;
    logic              w_key_ok;

    assign w_cur_idx  = r_mem[r_ptr];
    assign w_new_idx  = r_lfsr[IW-1:0];
    // len is always below MAX_LEN when a new step is written.
    assign w_wr_ptr   = r_len[PW-1:0];
    assign w_on_done  = (r_timer == ON_LAST);
    assign w_off_done = (r_timer == OFF_LAST);
    assign w_last     = ((LW'(r_ptr) + LW'(1)) == r_len);
    assign w_key_ok   = (key_onehot == w_exp_onehot);

    key_decoder #(
        .N_KEYS (N_KEYS)
    ) u_disp_dec (
        .i_en     (r_state == PLAY_ON),
        .i_idx    (w_cur_idx),
        .o_onehot (w_play_onehot)
    );

    key_decoder #(
        .N_KEYS (N_KEYS)
    ) u_exp_dec (
        .i_en     (r_state == WAIT_IN),
        .i_idx    (w_cur_idx),
        .o_onehot (w_exp_onehot)
    );

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_d;
        end
    end

    always_comb begin
        w_state_d = r_state;
        if (start) begin
            w_state_d = EXTEND;
        end else begin
            unique case (r_state)
                IDLE, WIN, LOSE: w_state_d = r_state;
                EXTEND:          w_state_d = PLAY_ON;
                PLAY_ON: begin
                    if (w_on_done) begin
                        w_state_d = PLAY_OFF;
                    end
                end
                PLAY_OFF: begin
                    if (w_off_done) begin
                        w_state_d = w_last ? WAIT_IN : PLAY_ON;
                    end
                end
                WAIT_IN: begin
                    if (key_valid) begin
                        if (!w_key_ok) begin
                            w_state_d = LOSE;
                        end else if (w_last) begin
                            w_state_d = (r_len == LEN_MAX) ? WIN : EXTEND;
                        end
                    end
                end
                default: w_state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        busy         = 1'b0;
        expect_input = 1'b0;
        win          = 1'b0;
        lose         = 1'b0;
        w_disp_d     = '0;
        unique case (r_state)
            EXTEND:   busy = 1'b1;
            PLAY_ON: begin
                busy     = 1'b1;
                w_disp_d = w_play_onehot;
            end
            PLAY_OFF: busy = 1'b1;
            WAIT_IN:  expect_input = 1'b1;
            WIN: begin
                win      = 1'b1;
                w_disp_d = '1;
            end
            LOSE:     lose = 1'b1;
            default:  ;
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_lfsr <= SEED;
            r_disp <= '0;
        end else begin
            r_lfsr <= lfsr_next(r_lfsr);
            r_disp <= start ? '0 : w_disp_d;
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_len   <= '0;
            r_ptr   <= '0;
            r_timer <= '0;
        end else if (start) begin
            r_len   <= '0;
            r_ptr   <= '0;
            r_timer <= '0;
        end else begin
            unique case (r_state)
                EXTEND: begin
                    r_len   <= r_len + LW'(1);
                    r_ptr   <= '0;
                    r_timer <= '0;
                end
                PLAY_ON: r_timer <= w_on_done ? '0 : r_timer + TW'(1);
                PLAY_OFF: begin
                    if (w_off_done) begin
                        r_timer <= '0;
                        r_ptr   <= w_last ? '0 : r_ptr + PW'(1);
                    end else begin
                        r_timer <= r_timer + TW'(1);
                    end
                end
                WAIT_IN: begin
                    if (key_valid && w_key_ok) begin
                        r_ptr <= w_last ? '0 : r_ptr + PW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Sequence storage carries no reset; stale steps are never replayed.
    always_ff @(posedge clk) begin
        if ((r_state == EXTEND) && !start) begin
            r_mem[w_wr_ptr] <= w_new_idx;
        end
    end

    assign disp  = r_disp;
    assign level = r_len;

endmodule

// File: tb/tb_simon_seq_gen.sv
// Directed bench for simon_seq_gen with a reference LFSR and expected-key log.
module tb_simon_seq_gen;

    localparam int unsigned N_KEYS     = 4;
    localparam int unsigned MAX_LEN    = 3;
    localparam int unsigned ON_CYCLES  = 2;
    localparam int unsigned OFF_CYCLES = 1;

    logic       clk = 1'b0;
    logic       nrst = 1'b0;
    logic       start = 1'b0;
    logic       key_valid = 1'b0;
    logic [3:0] key_onehot = 4'b0000;
    logic [3:0] disp;
    logic       busy;
    logic       expect_input;
    logic       win;
    logic       lose;
    logic [1:0] level;

    logic [15:0] m_lfsr;
    logic [1:0]  exp_seq [3];
    int          n_checks = 0;
    int          n_errors = 0;

    simon_seq_gen #(
        .N_KEYS     (N_KEYS),
        .MAX_LEN    (MAX_LEN),
        .ON_CYCLES  (ON_CYCLES),
        .OFF_CYCLES (OFF_CYCLES),
        .SEED       (16'hACE1)
    ) dut (
        .clk          (clk),
        .nrst         (nrst),
        .start        (start),
        .key_valid    (key_valid),
        .key_onehot   (key_onehot),
        .disp         (disp),
        .busy         (busy),
        .expect_input (expect_input),
        .win          (win),
        .lose         (lose),
        .level        (level)
    );

    always #5 clk = ~clk;

    always @(posedge clk or negedge nrst) begin
        if (!nrst) m_lfsr <= 16'hACE1;
        else       m_lfsr <= (m_lfsr >> 1) ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
    end

    function automatic logic [3:0] onehot(input logic [1:0] idx);
        logic [3:0] v;
        v = 4'b0001 << idx;
        return v;
    endfunction

    function automatic logic [3:0] wrong_of(input logic [1:0] idx);
        logic [1:0] w;
        w = idx + 2'd1;
        return onehot(w);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic do_start();
        start = 1'b1;
        cyc();
        start = 1'b0;
    endtask

    task automatic press(input logic [3:0] k);
        key_valid  = 1'b1;
        key_onehot = k;
        cyc();
        key_valid  = 1'b0;
        key_onehot = 4'b0000;
    endtask

    // Called one sample after the edge that entered EXTEND; ends in WAIT_IN.
    task automatic play_round(input int len);
        chk($sformatf("r%0d_extend_busy", len), busy, 1);
        chk($sformatf("r%0d_extend_win", len), win, 0);
        chk($sformatf("r%0d_extend_lose", len), lose, 0);
        exp_seq[len-1] = m_lfsr[1:0];
        cyc();
        chk($sformatf("r%0d_level", len), level, len);
        chk($sformatf("r%0d_disp_pre", len), disp, 0);
        for (int s = 0; s < len; s++) begin
            for (int c = 0; c < 2; c++) begin
                cyc();
                chk($sformatf("r%0d_s%0d_c%0d_disp_on", len, s, c), disp, onehot(exp_seq[s]));
                chk($sformatf("r%0d_s%0d_c%0d_busy", len, s, c), busy, 1);
            end
            cyc();
            chk($sformatf("r%0d_s%0d_disp_off", len, s), disp, 0);
        end
        chk($sformatf("r%0d_expect_input", len), expect_input, 1);
        chk($sformatf("r%0d_waitin_busy", len), busy, 0);
    endtask

    initial begin
        repeat (2) cyc();
        chk("rst_disp", disp, 0);
        chk("rst_busy", busy, 0);
        chk("rst_expect", expect_input, 0);
        chk("rst_win", win, 0);
        chk("rst_lose", lose, 0);
        chk("rst_level", level, 0);

        // Round 1 from the first edge after release; key 0 from lfsr E270.
        nrst = 1'b1;
        do_start();
        play_round(1);
        repeat (3) cyc();
        chk("r1_wait_hold", expect_input, 1);
        chk("r1_wait_disp", disp, 0);

        press(onehot(exp_seq[0]));
        play_round(2);
        press(onehot(exp_seq[0]));
        chk("r2_mid_expect", expect_input, 1);
        chk("r2_mid_lose", lose, 0);
        press(onehot(exp_seq[1]));
        play_round(3);
        press(onehot(exp_seq[0]));
        press(onehot(exp_seq[1]));
        press(onehot(exp_seq[2]));
        chk("win_flag", win, 1);
        chk("win_level", level, 3);
        chk("win_busy", busy, 0);
        cyc();
        chk("win_disp", disp, 4'b1111);
        repeat (5) cyc();
        press(4'b0000);
        chk("win_hold", win, 1);
        chk("win_hold_lose", lose, 0);
        chk("win_hold_disp", disp, 4'b1111);

        // Wrong one-hot key, then hold LOSE for 20 cycles.
        do_start();
        play_round(1);
        press(wrong_of(exp_seq[0]));
        chk("lose_flag", lose, 1);
        chk("lose_expect", expect_input, 0);
        for (int i = 0; i < 20; i++) begin
            cyc();
            chk($sformatf("lose_hold%0d", i), lose, 1);
            chk($sformatf("lose_disp%0d", i), disp, 0);
        end

        // Abort during round-2 playback; stray key_valid while playing.
        do_start();
        play_round(1);
        press(onehot(exp_seq[0]));
        chk("abort_extend_busy", busy, 1);
        exp_seq[1] = m_lfsr[1:0];
        cyc();
        key_valid  = 1'b1;
        key_onehot = 4'b0000;
        cyc();
        key_valid  = 1'b0;
        chk("abort_play_disp", disp, onehot(exp_seq[0]));
        chk("abort_play_lose", lose, 0);
        chk("abort_play_busy", busy, 1);
        do_start();
        chk("abort_level_clr", level, 0);
        play_round(1);

        // Start and a wrong key in the same cycle: start wins.
        start      = 1'b1;
        key_valid  = 1'b1;
        key_onehot = wrong_of(exp_seq[0]);
        cyc();
        start      = 1'b0;
        key_valid  = 1'b0;
        key_onehot = 4'b0000;
        play_round(1);

        press(4'b0011);
        chk("lose_multihot", lose, 1);
        do_start();
        play_round(1);
        press(4'b0000);
        chk("lose_zero", lose, 1);

        // Asynchronous reset while a step is lit.
        do_start();
        cyc();
        cyc();
        chk("pre_rst_busy", busy, 1);
        #2 nrst = 1'b0;
        #1;
        chk("arst_disp", disp, 0);
        chk("arst_busy", busy, 0);
        chk("arst_level", level, 0);
        chk("arst_lose", lose, 0);
        cyc();
        nrst = 1'b1;
        do_start();
        cyc();
        cyc();
        chk("restart_disp_hand", disp, 4'b0001);
        chk("restart_level", level, 1);
        cyc();
        cyc();
        chk("restart_expect", expect_input, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/simon_seq_gen.md
# simon_seq_gen

Parametrised Simon Says sequence engine: grows a random key sequence by one step per round, plays it back as timed one-hot display pulses, then checks the player's key presses against it. Sits between the debounced button/keypad front end and the LED/7-seg display driver. It replaces a fixed 16-key, purely combinational index-to-one-hot stage with a stateful game core. It also adds sequence storage, playback timing and win/lose detection.

## Interface
- N_KEYS, 16, number of keys / one-hot display width; power of two, 2..16
- MAX_LEN, 32, longest sequence (rounds to win); 1..64
- ON_CYCLES, 8, clock cycles each step is lit during playback; ≥1
- OFF_CYCLES, 4, dark gap after each step; ≥1
- SEED, 16'hACE1, LFSR reset value; must be nonzero
- clk  in  1  system clock, single domain
- nrst  in  1  reset, asynchronous, active-low
- start  in  1  pulse: clear sequence, begin round 1 (honoured in every state, highest priority)
- key_valid  in  1  one-cycle strobe, player key press
- key_onehot  in  N_KEYS  pressed key, expected one-hot
- disp  out  N_KEYS  registered one-hot playback output
- busy  out  1  high in EXTEND/PLAY_ON/PLAY_OFF
- expect_input  out  1  high in WAIT_IN
- win  out  1  held high in WIN until start
- lose  out  1  held high in LOSE until start
- level  out  $clog2(MAX_LEN+1)  current sequence length

## Operation
- LFSR: 16-bit Galois, right shift, next = (l>>1) ^ (l[0] ? 16'hB400 : 0), steps every clk edge in all states; key index = l[$clog2(N_KEYS)-1:0].
- Storage: MAX_LEN × $clog2(N_KEYS) register array, index ptr, length len.
- IDLE: all outputs 0. start → len=0, EXTEND.
- EXTEND (1 cycle): mem[len] ← LFSR index; len ← len+1; ptr ← 0; timer ← 0 → PLAY_ON.
- PLAY_ON: disp = onehot(mem[ptr]) for ON_CYCLES cycles → PLAY_OFF.
- PLAY_OFF: disp = 0 for OFF_CYCLES cycles; then ptr+1==len ? (ptr←0, WAIT_IN) : (ptr++, PLAY_ON).
- WAIT_IN: key_valid with key_onehot == onehot(mem[ptr]) → if ptr+1==len: len==MAX_LEN ? WIN : EXTEND; else ptr++. Any other key_onehot value, including zero or multi-hot → LOSE.
- key_valid outside WAIT_IN ignored.
- WIN: disp = all ones. LOSE: disp = 0. Flags held; only start or reset leaves these states.
- start in any state: len and ptr cleared, win and lose cleared next cycle, → EXTEND. Old memory contents are don't-care.
- level = len, saturates at MAX_LEN by construction.

## Timing
- Reset: state IDLE, disp=0, busy=0, expect_input=0, win=0, lose=0, level=0, lfsr=SEED, len=ptr=timer=0.
- start sampled at edge t → EXTEND during t..t+1 → first step lit from edge t+2 for exactly ON_CYCLES cycles.
- Round playback length = len×(ON_CYCLES+OFF_CYCLES) cycles, plus 1 EXTEND cycle.
- Key check result registered: correct final key at edge t → EXTEND (busy=1) at t+1; wrong key at edge t → lose=1 at t+1.
- Simultaneous start and key_valid: start wins.
- Reset asserted mid-play: immediate return to the reset values above.

## Structure
- Package simon_pkg: state enum (IDLE, EXTEND, PLAY_ON, PLAY_OFF, WAIT_IN, WIN, LOSE), LFSR_TAPS = 16'hB400.
- One sub-module: key_decoder, parametrised N_KEYS index-to-one-hot decoder with enable, zero when disabled or out of range. Instantiated for disp generation and for the expected-key compare.
- Timer, LFSR, memory and FSM in the top module.

## Test plan
Bench parameters: N_KEYS=4, MAX_LEN=3, ON_CYCLES=2, OFF_CYCLES=1. The bench keeps an LFSR model.
- Reset, then start at the first edge after release. EXTEND samples lfsr=16'hE270 → mem[0]=0. disp=4'b0001 for 2 cycles, then 0 for 1 cycle, then expect_input=1, level=1.
- In WAIT_IN, correct key 4'b0001 → busy=1 next cycle, level=2, round-2 playback of 2 steps (7 cycles including EXTEND).
- Wrong key, non-one-hot 4'b0011, or 4'b0000 → lose=1 next cycle, disp=0, held for 20 cycles until start.
- Complete 3 rounds correctly → win=1, disp=4'b1111, level=3, held until start.
- start during PLAY_ON of round 2 → level=1 two cycles later, win/lose=0, new step plays. key_valid pulsed during playback has no effect.
- nrst asserted mid-PLAY_ON → all outputs 0 asynchronously. After release, LFSR restarts at 16'hACE1.
